adc_conv_scheduler: RTL and testbench

- Shares one registered code-to-millivolt converter between NUM_SRC ADC paths (discrete PWM ADC, R-2R ADC, ...).
- Each path raises a 1-cycle strobe when a new averaged 8-bit code is ready.
- The scheduler buffers one code per source and grants the converter round-robin.
- It drives the converter enable/code, captures the millivolt result after CONV_LATENCY cycles, and returns it to the owning source with a 1-cycle valid.

---
 rtl/adc_conv_scheduler.sv | 161 ++++++++++++++++
 tb/tb_adc_conv_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler
// Shares one registered code-to-millivolt converter among NUM_SRC ADC paths.
// Each source has a one-deep code buffer. Buffered sources are granted the
// converter in round-robin order. The millivolt result goes back to the
// owning source together with a one-cycle valid pulse.
module adc_conv_scheduler #(
    parameter int NUM_SRC      = 2,
    parameter int CONV_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SRC-1:0]      req_strobe,
    input  logic [NUM_SRC*8-1:0]    req_code,
    input  logic [NUM_SRC-1:0]      clr_overrun,
    output logic                    conv_en,
    output logic [7:0]              conv_code,
    input  logic [15:0]             conv_mV,
    output logic [NUM_SRC*16-1:0]   res_mV,
    output logic [NUM_SRC-1:0]      res_valid,
    output logic [NUM_SRC-1:0]      overrun,
    output logic                    busy
);

    localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW = (CONV_LATENCY > 1) ? $clog2(CONV_LATENCY) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]         state_reg;
    logic [GW-1:0]      grant_reg;
    logic [GW-1:0]      last_grant_reg;
    logic [CW-1:0]      wait_cnt_reg;
    logic [NUM_SRC-1:0] pending_reg;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] overrun_next;
    logic [NUM_SRC-1:0] issue_hit;
    logic [NUM_SRC-1:0] grant_onehot;
    logic [7:0]         code_reg [NUM_SRC];
    logic [7:0]         in_code  [NUM_SRC];

    logic               pick_found;
    logic [GW-1:0]      pick_idx;
    logic               capture;

    // The result is present on conv_mV in the last WAIT cycle.
    assign capture = (state_reg == WAIT) && (wait_cnt_reg == '0);
    assign busy    = (state_reg != IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign in_code[gi]      = req_code[gi*8 +: 8];
            assign grant_onehot[gi] = (grant_reg == GW'(gi));
            // This source's buffered code is handed to the converter this cycle.
            assign issue_hit[gi]    = (state_reg == ISSUE) && grant_onehot[gi];
            // A new strobe always refills the buffer, even while the old code issues.
            assign pending_next[gi] = req_strobe[gi] | (pending_reg[gi] & ~issue_hit[gi]);
            // An overwrite of a code that is still waiting is an overrun; a set beats a clear.
            assign overrun_next[gi] = (req_strobe[gi] & pending_reg[gi] & ~issue_hit[gi]) |
                                      (overrun[gi] & ~clr_overrun[gi]);
        end
    endgenerate

    // Round-robin pick: first pending source after the last grant.
    always_comb begin
        int cand;
        pick_found = 1'b0;
        pick_idx   = last_grant_reg;
        cand       = 0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = int'(last_grant_reg) + i;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!pick_found && pending_reg[GW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(cand);
            end
        end
    end

    // Per-source buffers: pending flag, latched code and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
            overrun     <= '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                code_reg[s] <= 8'd0;
            end
        end else begin
            pending_reg <= pending_next;
            overrun     <= overrun_next;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (req_strobe[s]) begin
                    code_reg[s] <= in_code[s];
                end
            end
        end
    end

    // Scheduler FSM and converter drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= GW'(NUM_SRC - 1);
            wait_cnt_reg   <= '0;
            conv_en        <= 1'b0;
            conv_code      <= 8'd0;
        end else begin
            conv_en <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        grant_reg      <= pick_idx;
                        last_grant_reg <= pick_idx;
                        conv_en        <= 1'b1;
                        // A strobe landing on the grant edge is the newest code; forward it.
                        conv_code      <= req_strobe[pick_idx] ? in_code[pick_idx]
                                                               : code_reg[pick_idx];
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt_reg <= CW'(CONV_LATENCY - 1);
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt_reg == '0) begin
                        state_reg <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - CW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Result capture into the granted slice, with a one-cycle valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_mV    <= '0;
            res_valid <= '0;
        end else begin
            res_valid <= capture ? grant_onehot : '0;
            if (capture) begin
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (grant_onehot[s]) begin
                        res_mV[s*16 +: 16] <= conv_mV;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Directed bench for adc_conv_scheduler: one instance with CONV_LATENCY=1 and
// one with CONV_LATENCY=3, each fed by a converter model whose output is
// only valid in the exact cycle the result is due.
`timescale 1ns/1ps
module tb_adc_conv_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: latency 1
    logic        reset = 1'b1;
    logic [1:0]  req_strobe = '0;
    logic [15:0] req_code = '0;
    logic [1:0]  clr_overrun = '0;
    logic        conv_en;
    logic [7:0]  conv_code;
    logic [15:0] conv_mV;
    logic [31:0] res_mV;
    logic [1:0]  res_valid;
    logic [1:0]  overrun;
    logic        busy;

    // Instance B: latency 3
    logic        reset_b = 1'b1;
    logic [1:0]  req_strobe_b = '0;
    logic [15:0] req_code_b = '0;
    logic [1:0]  clr_overrun_b = '0;
    logic        conv_en_b;
    logic [7:0]  conv_code_b;
    logic [15:0] conv_mV_b;
    logic [31:0] res_mV_b;
    logic [1:0]  res_valid_b;
    logic [1:0]  overrun_b;
    logic        busy_b;

    adc_conv_scheduler #(.NUM_SRC(2), .CONV_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .req_strobe(req_strobe), .req_code(req_code),
        .clr_overrun(clr_overrun), .conv_en(conv_en), .conv_code(conv_code),
        .conv_mV(conv_mV), .res_mV(res_mV), .res_valid(res_valid),
        .overrun(overrun), .busy(busy)
    );

    adc_conv_scheduler #(.NUM_SRC(2), .CONV_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset_b), .req_strobe(req_strobe_b), .req_code(req_code_b),
        .clr_overrun(clr_overrun_b), .conv_en(conv_en_b), .conv_code(conv_code_b),
        .conv_mV(conv_mV_b), .res_mV(res_mV_b), .res_valid(res_valid_b),
        .overrun(overrun_b), .busy(busy_b)
    );

    function automatic logic [15:0] mv(input logic [7:0] c);
        int t;
        t = int'(c) * 3300 / 255;
        return t[15:0];
    endfunction

    // Converter models: result valid exactly CONV_LATENCY cycles after enable, 0xDEAD otherwise.
    logic        va = 1'b0;
    logic [15:0] da = '0;
    always @(posedge clk) begin
        va <= conv_en;
        da <= mv(conv_code);
    end
    assign conv_mV = va ? da : 16'hDEAD;

    logic [2:0]  vb = '0;
    logic [15:0] db0 = '0, db1 = '0, db2 = '0;
    always @(posedge clk) begin
        vb  <= {vb[1:0], conv_en_b};
        db0 <= mv(conv_code_b);
        db1 <= db0;
        db2 <= db1;
    end
    assign conv_mV_b = vb[2] ? db2 : 16'hDEAD;

    // Monitors on instance A (only writers of these variables).
    logic [7:0] conv_log[$];
    int rv_cnt0 = 0, rv_cnt1 = 0, multi_hot = 0;
    always @(posedge clk) begin
        if (conv_en) conv_log.push_back(conv_code);
        if (res_valid[0]) rv_cnt0 = rv_cnt0 + 1;
        if (res_valid[1]) rv_cnt1 = rv_cnt1 + 1;
        if (res_valid == 2'b11) multi_hot = multi_hot + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_strobe = '0;
        clr_overrun = '0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        reset_b = 1'b1;
        tick();
        tick();
        checks++; if (conv_en !== 1'b0) begin errors++; $display("FAIL reset_conv_en: got %0b want 0", conv_en); end
        checks++; if (conv_code !== 8'h00) begin errors++; $display("FAIL reset_conv_code: got %0h want 0", conv_code); end
        checks++; if (res_mV !== 32'h0) begin errors++; $display("FAIL reset_res_mV: got %0h want 0", res_mV); end
        checks++; if ({res_valid, overrun, busy} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {res_valid, overrun, busy}); end
        reset = 1'b0;
        reset_b = 1'b0;
        tick();
        // cycle 0
        req_strobe = 2'b01;
        req_code = 16'h00FF;
        tick();
        req_strobe = '0;
        // cycle 1
        checks++; if ({busy, conv_en} !== 2'b00) begin errors++; $display("FAIL c1_idle: got %b want 00", {busy, conv_en}); end
        tick();
        // cycle 2
        checks++; if ({conv_en, conv_code} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL c2_issue: got en=%0b code=%0h want en=1 code=ff", conv_en, conv_code); end
        tick();
        // cycle 3
        checks++; if (res_valid !== 2'b00) begin errors++; $display("FAIL c3_no_valid: got %b want 00", res_valid); end
        tick();
        // cycle 4
        checks++; if (res_valid !== 2'b01) begin errors++; $display("FAIL c4_valid: got %b want 01", res_valid); end
        checks++; if (res_mV[15:0] !== 16'd3300) begin errors++; $display("FAIL c4_res0: got %0d want 3300", res_mV[15:0]); end
        $display("test_reset done");
    endtask

    task automatic test_two_sources;
        int first = -1, second = -1;
        logic [7:0] code1 = '0, code2 = '0;
        do_reset();
        req_strobe = 2'b11;
        req_code = {8'h40, 8'h80};
        for (int c = 0; c < 12; c++) begin
            if (conv_en) begin
                if (first < 0) begin first = c; code1 = conv_code; end
                else if (second < 0) begin second = c; code2 = conv_code; end
            end
            tick();
            req_strobe = '0;
        end
        checks++; if (first !== 2 || code1 !== 8'h80) begin errors++; $display("FAIL two_first: got cyc=%0d code=%0h want cyc=2 code=80", first, code1); end
        checks++; if (second !== 5 || code2 !== 8'h40) begin errors++; $display("FAIL two_second: got cyc=%0d code=%0h want cyc=5 code=40", second, code2); end
        checks++; if (res_mV[15:0] !== 16'd1656) begin errors++; $display("FAIL two_res0: got %0d want 1656", res_mV[15:0]); end
        checks++; if (res_mV[31:16] !== 16'd828) begin errors++; $display("FAIL two_res1: got %0d want 828", res_mV[31:16]); end
        $display("test_two_sources done");
    endtask

    task automatic test_round_robin;
        int start;
        do_reset();
        start = conv_log.size();
        req_code = {8'h22, 8'h11};
        req_strobe = 2'b11;
        for (int n = 0; n < 100 && (conv_log.size() - start) < 10; n++) tick();
        req_strobe = '0;
        checks++;
        if (conv_log.size() - start < 10) begin
            errors++; $display("FAIL rr_timeout: got %0d grants want 10", conv_log.size() - start);
        end else begin
            for (int i = 0; i < 10; i++) begin
                logic [7:0] want;
                want = (i % 2 == 0) ? 8'h11 : 8'h22;
                checks++;
                if (conv_log[start + i] !== want) begin errors++; $display("FAIL rr_grant%0d: got %0h want %0h", i, conv_log[start + i], want); end
            end
        end
        for (int n = 0; n < 10; n++) tick();
        $display("test_round_robin done");
    endtask

    task automatic test_overrun;
        int start, r0, r1;
        do_reset();
        start = conv_log.size();
        r0 = rv_cnt0;
        r1 = rv_cnt1;
        req_strobe = 2'b01; req_code = 16'h0033;
        tick(); req_strobe = '0;          // cycle 1
        tick();                           // cycle 2: src0 in ISSUE
        req_strobe = 2'b10; req_code = 16'h1000;
        tick();                           // cycle 3
        req_strobe = 2'b10; req_code = 16'h2000;
        tick(); req_strobe = '0;          // cycle 4
        checks++; if (overrun !== 2'b10) begin errors++; $display("FAIL ovr_set: got %b want 10", overrun); end
        for (int n = 0; n < 10; n++) tick();
        checks++; if (conv_log.size() - start !== 2) begin errors++; $display("FAIL ovr_grants: got %0d want 2", conv_log.size() - start); end
        else begin
            checks++; if (conv_log[start] !== 8'h33 || conv_log[start + 1] !== 8'h20) begin errors++; $display("FAIL ovr_codes: got %0h,%0h want 33,20", conv_log[start], conv_log[start + 1]); end
        end
        checks++; if (rv_cnt1 - r1 !== 1 || rv_cnt0 - r0 !== 1) begin errors++; $display("FAIL ovr_valids: got src0=%0d src1=%0d want 1,1", rv_cnt0 - r0, rv_cnt1 - r1); end
        checks++; if (res_mV[31:16] !== 16'd414) begin errors++; $display("FAIL ovr_res1: got %0d want 414", res_mV[31:16]); end
        checks++; if (overrun !== 2'b10) begin errors++; $display("FAIL ovr_sticky: got %b want 10", overrun); end
        clr_overrun = 2'b10;
        tick(); clr_overrun = '0;
        checks++; if (overrun !== 2'b00) begin errors++; $display("FAIL ovr_clear: got %b want 00", overrun); end
        $display("test_overrun done");
    endtask

    task automatic test_boundaries;
        int start, r0;
        do_reset();
        start = conv_log.size();
        r0 = rv_cnt0;
        req_strobe = 2'b01; req_code = 16'h0001;
        tick(); req_strobe = '0;          // cycle 1
        tick();                           // cycle 2: src0 in ISSUE, new strobe
        req_strobe = 2'b01; req_code = 16'h0002;
        tick(); req_strobe = '0;          // cycle 3
        checks++; if (overrun !== 2'b00) begin errors++; $display("FAIL issue_strobe_no_ovr: got %b want 00", overrun); end
        for (int n = 0; n < 8; n++) tick();
        checks++; if (rv_cnt0 - r0 !== 2) begin errors++; $display("FAIL issue_strobe_valids: got %0d want 2", rv_cnt0 - r0); end
        checks++; if (res_mV[15:0] !== 16'd25) begin errors++; $display("FAIL issue_strobe_res: got %0d want 25", res_mV[15:0]); end
        // Set and clear of overrun in the same cycle: set wins; newest code is issued.
        req_strobe = 2'b01; req_code = 16'h0003;
        tick();
        req_strobe = 2'b01; req_code = 16'h0004; clr_overrun = 2'b01;
        tick(); req_strobe = '0; clr_overrun = '0;
        checks++; if (overrun !== 2'b01) begin errors++; $display("FAIL set_wins: got %b want 01", overrun); end
        for (int n = 0; n < 8; n++) tick();
        checks++; if (conv_log.size() - start !== 3) begin errors++; $display("FAIL bnd_grants: got %0d want 3", conv_log.size() - start); end
        else begin
            checks++; if (conv_log[start + 1] !== 8'h02 || conv_log[start + 2] !== 8'h04) begin errors++; $display("FAIL bnd_codes: got %0h,%0h want 02,04", conv_log[start + 1], conv_log[start + 2]); end
        end
        $display("test_boundaries done");
    endtask

    task automatic test_reset_abort;
        int r1;
        do_reset();
        req_strobe = 2'b01; req_code = 16'h00FF;
        tick(); req_strobe = '0;
        for (int n = 0; n < 6; n++) tick();
        req_strobe = 2'b10; req_code = 16'h8000;   // cycle 0
        tick();
        req_strobe = 2'b10; req_code = 16'h9000;   // cycle 1: overwrite while pending
        tick(); req_strobe = '0;                   // cycle 2: ISSUE
        tick();                                    // cycle 3: WAIT
        checks++; if ({busy, overrun} !== 3'b110) begin errors++; $display("FAIL abort_pre: got busy=%0b ovr=%b want busy=1 ovr=10", busy, overrun); end
        r1 = rv_cnt1;
        #2 reset = 1'b1;
        #1;
        checks++; if ({conv_en, conv_code, res_valid, overrun, busy} !== 14'h0) begin errors++; $display("FAIL abort_flags: got en=%0b code=%0h rv=%b ovr=%b busy=%0b want all 0", conv_en, conv_code, res_valid, overrun, busy); end
        checks++; if (res_mV !== 32'h0) begin errors++; $display("FAIL abort_res: got %0h want 0", res_mV); end
        tick();
        reset = 1'b0;
        for (int n = 0; n < 6; n++) tick();
        checks++; if (rv_cnt1 - r1 !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d want 0", rv_cnt1 - r1); end
        req_strobe = 2'b10; req_code = 16'h8000;
        tick(); req_strobe = '0;
        for (int n = 0; n < 8; n++) tick();
        checks++; if (rv_cnt1 - r1 !== 1 || res_mV[31:16] !== 16'd1656) begin errors++; $display("FAIL abort_recover: got valids=%0d res=%0d want 1,1656", rv_cnt1 - r1, res_mV[31:16]); end
        $display("test_reset_abort done");
    endtask

    task automatic test_latency3;
        int en_cyc = -1, rv_cyc = -1;
        logic [1:0] rv_seen = '0;
        reset_b = 1'b1;
        tick();
        reset_b = 1'b0;
        tick();
        req_strobe_b = 2'b01; req_code_b = 16'h00FF;
        for (int c = 0; c < 12; c++) begin
            if (conv_en_b && en_cyc < 0) en_cyc = c;
            if (res_valid_b != 2'b00 && rv_cyc < 0) begin rv_cyc = c; rv_seen = res_valid_b; end
            tick();
            req_strobe_b = '0;
        end
        checks++; if (en_cyc !== 2) begin errors++; $display("FAIL lat3_en: got cyc=%0d want 2", en_cyc); end
        checks++; if (rv_cyc !== 6 || rv_seen !== 2'b01) begin errors++; $display("FAIL lat3_valid: got cyc=%0d rv=%b want cyc=6 rv=01", rv_cyc, rv_seen); end
        checks++; if (res_mV_b[15:0] !== 16'd3300) begin errors++; $display("FAIL lat3_res: got %0h want %0h", res_mV_b[15:0], 16'd3300); end
        $display("test_latency3 done");
    endtask

    initial begin
        test_reset();
        test_two_sources();
        test_round_robin();
        test_overrun();
        test_boundaries();
        test_reset_abort();
        test_latency3();
        checks++; if (multi_hot !== 0) begin errors++; $display("FAIL onehot_valid: got %0d multi-hot cycles want 0", multi_hot); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
